// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the SRAM-like port arbiter: requester select codes,
// default outstanding depth and lock-state encodings.
package sram_port_arbiter_pkg;

    localparam int OUTSTANDING_DEF = 4;

    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    typedef enum logic {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage

// File: rtl/sram_port_arbiter_arb_owner_fifo.sv
// 1-bit-wide synchronous FIFO remembering which requester owns each accepted
// transaction; async active-high reset, full/empty/count status.
module arb_owner_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter  int DEPTH = OUTSTANDING_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_bit,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             head
);

    logic [DEPTH-1:0] mem_q,    mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == {CNT_W{1'b0}});
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_bit;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between inst and data requesters with in-order
// response routing. Define ARB_RR_EN for round-robin instead of data priority.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic                i_wr,
    input  logic [1:0]          i_size,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [1:0]          d_size,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    lock_state_t      lock_q, lock_d;
    logic             lock_sel_q, lock_sel_d;
    logic             sel_s;
    logic             req_sel_s;
    logic             accept_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_head_s;
    logic [CNT_W-1:0] fifo_count_s;

`ifdef ARB_RR_EN
    logic last_grant_q, last_grant_d;
`endif

    // Grant selection: a held lock pins the owner until its request is accepted.
    always_comb begin
        sel_s = SEL_INST;
        if (lock_q == LOCK_HELD) begin
            sel_s = lock_sel_q;
`ifdef ARB_RR_EN
        end else if (i_req && d_req) begin
            sel_s = ~last_grant_q;
`endif
        end else if (d_req) begin
            sel_s = SEL_DATA;
        end else begin
            sel_s = SEL_INST;
        end
    end

    // Request field mux towards the downstream port.
    always_comb begin
        req_sel_s = i_req;
        m_wr      = i_wr;
        m_size    = i_size;
        m_wstrb   = i_wstrb;
        m_addr    = i_addr;
        m_wdata   = i_wdata;
        if (sel_s == SEL_DATA) begin
            req_sel_s = d_req;
            m_wr      = d_wr;
            m_size    = d_size;
            m_wstrb   = d_wstrb;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
        end else begin
            req_sel_s = i_req;
        end
    end

    // No bypass on full: a same-cycle data_ok does not free a slot until next cycle.
    assign m_req     = req_sel_s & ~fifo_full_s;
    assign accept_s  = m_req & m_addr_ok;
    assign i_addr_ok = accept_s & (sel_s == SEL_INST);
    assign d_addr_ok = accept_s & (sel_s == SEL_DATA);

    assign pop_s     = m_data_ok & (fifo_count_s != {CNT_W{1'b0}});
    assign i_data_ok = m_data_ok & ~fifo_empty_s & (fifo_head_s == SEL_INST);
    assign d_data_ok = m_data_ok & ~fifo_empty_s & (fifo_head_s == SEL_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    // Lock FSM next state.
    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        case (lock_q)
            LOCK_FREE: begin
                if (m_req && !m_addr_ok) begin
                    lock_d     = LOCK_HELD;
                    lock_sel_d = sel_s;
                end else begin
                    lock_d = LOCK_FREE;
                end
            end
            LOCK_HELD: begin
                if (accept_s) begin
                    lock_d = LOCK_FREE;
                end else begin
                    lock_d = LOCK_HELD;
                end
            end
            default: lock_d = LOCK_FREE;
        endcase
    end

    // Lock state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= LOCK_FREE;
            lock_sel_q <= SEL_INST;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

`ifdef ARB_RR_EN
    // Last granted requester, reset to data so inst wins the first tie.
    always_comb begin
        if (accept_s) begin
            last_grant_d = sel_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= SEL_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept_s),
        .push_bit (sel_s),
        .pop      (pop_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s),
        .head     (fifo_head_s)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected {owner, rdata},
// a monitor pops and compares on every i/d_data_ok.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [32:0] exp_q[$];

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h8000_2000;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One cycle of stimulus, applied at the falling edge; checks follow at +2.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic aok, input logic dok,
                        input logic [31:0] rd);
        @(negedge clk);
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
        m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
        #2;
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] rd);
        exp_q.push_back({owner, rd});
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [32:0] e;
        #3;
        if (i_data_ok || d_data_ok) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {30'd0, i_data_ok, d_data_ok}, e[32] ? 32'd1 : 32'd2);
                chk("rsp_rdata", e[32] ? d_rdata : i_rdata, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        i_req = 1'b0; i_wr = 1'b0; i_size = 2'd2; i_wstrb = 4'h0; i_addr = 32'd0; i_wdata = 32'd0;
        d_req = 1'b0; d_wr = 1'b1; d_size = 2'd1; d_wstrb = 4'hC; d_addr = 32'd0; d_wdata = 32'hCAFE_F00D;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
        #2;
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Inst-only read, accepted immediately, answered two cycles later.
        step(1'b1, IA, 1'b0, DA, 1'b1, 1'b0, 32'd0);
        chk("t1_m_req", {31'd0, m_req}, 32'd1);
        chk("t1_m_addr", m_addr, IA);
        chk("t1_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        push_exp(1'b0, 32'h0280_0C0C);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b0, 32'd0);
        chk("t1_idle_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h0280_0C0C);
        chk("t1_d_quiet", {30'd0, d_addr_ok, d_data_ok}, 32'd0);

        // Both request: data first (priority, or round-robin after an inst grant).
        step(1'b1, IA + 32'h4, 1'b1, DA, 1'b1, 1'b0, 32'd0);
        chk("t2_m_addr_d", m_addr, DA);
        chk("t2_m_wr_d", {31'd0, m_wr}, 32'd1);
        chk("t2_m_wstrb_d", {28'd0, m_wstrb}, 32'hC);
        chk("t2_addr_ok_d", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
        push_exp(1'b1, 32'hD000_0001);
        step(1'b1, IA + 32'h4, 1'b0, DA, 1'b1, 1'b0, 32'd0);
        chk("t2_m_addr_i", m_addr, IA + 32'h4);
        chk("t2_m_wr_i", {31'd0, m_wr}, 32'd0);
        chk("t2_addr_ok_i", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        push_exp(1'b0, 32'h1000_0002);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'hD000_0001);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h1000_0002);

        // Stalled inst request holds the port while data waits.
        step(1'b1, IA + 32'h8, 1'b0, DA + 32'h10, 1'b0, 1'b0, 32'd0);
        chk("t3_c0_m_addr", m_addr, IA + 32'h8);
        for (int c = 1; c < 3; c++) begin
            step(1'b1, IA + 32'h8, 1'b1, DA + 32'h10, 1'b0, 1'b0, 32'd0);
            chk("t3_held_m_addr", m_addr, IA + 32'h8);
            chk("t3_held_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        end
        step(1'b1, IA + 32'h8, 1'b1, DA + 32'h10, 1'b1, 1'b0, 32'd0);
        chk("t3_acc_m_addr", m_addr, IA + 32'h8);
        chk("t3_acc_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd2);
        push_exp(1'b0, 32'h3000_0003);
        step(1'b0, IA, 1'b1, DA + 32'h10, 1'b1, 1'b0, 32'd0);
        chk("t3_d_m_addr", m_addr, DA + 32'h10);
        chk("t3_d_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
        push_exp(1'b1, 32'h3000_0004);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h3000_0003);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h3000_0004);

        // Fill the owner FIFO (i,d,d,i), then hit the full boundary.
        step(1'b1, IA, 1'b0, DA, 1'b1, 1'b0, 32'd0); push_exp(1'b0, 32'h4000_0001);
        step(1'b0, IA, 1'b1, DA, 1'b1, 1'b0, 32'd0); push_exp(1'b1, 32'h4000_0002);
        step(1'b0, IA, 1'b1, DA, 1'b1, 1'b0, 32'd0); push_exp(1'b1, 32'h4000_0003);
        step(1'b1, IA, 1'b0, DA, 1'b1, 1'b0, 32'd0); push_exp(1'b0, 32'h4000_0004);
        step(1'b0, IA, 1'b1, DA, 1'b1, 1'b1, 32'h4000_0001);
        chk("t4_full_m_req", {31'd0, m_req}, 32'd0);
        chk("t4_full_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd0);
        step(1'b0, IA, 1'b1, DA, 1'b1, 1'b0, 32'd0);
        chk("t4_after_m_req", {31'd0, m_req}, 32'd1);
        chk("t4_after_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, 32'd1);
        push_exp(1'b1, 32'h4000_0005);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h4000_0002);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h4000_0003);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h4000_0004);
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h4000_0005);

        // Reset with two outstanding, then a stray data_ok must be dropped.
        step(1'b1, IA, 1'b0, DA, 1'b1, 1'b0, 32'd0);
        step(1'b0, IA, 1'b1, DA, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h5555_5555;
        reset = 1'b1;
        #2;
        chk("t5_rst_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
        chk("t5_rst_m_req", {31'd0, m_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_data_ok = 1'b0;
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h5555_5555);
        chk("t5_stray_data_ok", {30'd0, i_data_ok, d_data_ok}, 32'd0);
        chk("t5_idle_m_req", {31'd0, m_req}, 32'd0);

        // Continuous contention after reset.
        for (int c = 0; c < 4; c++) begin
`ifdef ARB_RR_EN
            logic own = (c % 2 == 1);
`else
            logic own = 1'b1;
`endif
            step(1'b1, IA + 32'h20, 1'b1, DA + 32'h20, 1'b1, 1'b0, 32'd0);
            chk("t6_m_addr", m_addr, own ? DA + 32'h20 : IA + 32'h20);
            chk("t6_addr_ok", {30'd0, i_addr_ok, d_addr_ok}, own ? 32'd1 : 32'd2);
            push_exp(own, 32'h6000_0000 + 32'(c));
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, IA, 1'b0, DA, 1'b0, 1'b1, 32'h6000_0000 + 32'(c));
        end
        step(1'b0, IA, 1'b0, DA, 1'b0, 1'b0, 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline's inst/data SRAM-like interfaces and the downstream bridge.
- Tracks up to OUTSTANDING accepted-but-unanswered transactions. Routes each in-order response back to its originator.

Parameters:
- OUTSTANDING, 4, max accepted transactions awaiting data_ok (power of two, >=2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  inst requester: request valid
- i_wr  in  1  inst: write (normally 0)
- i_size  in  2  inst: bytes = 1<<size
- i_wstrb  in  DATA_W/8  inst: byte strobes
- i_addr  in  ADDR_W  inst: address
- i_wdata  in  DATA_W  inst: write data
- i_addr_ok  out  1  inst: request accepted
- i_data_ok  out  1  inst: response valid
- i_rdata  out  DATA_W  inst: read data
- d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata  in  (same widths)  data requester, same meanings
- d_addr_ok, d_data_ok, d_rdata  out  (same widths)  data requester, same meanings
- m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  (same widths)  downstream request
- m_addr_ok, m_data_ok  in  1  downstream accept/response
- m_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (async, immediate):
  - lock cleared and owner-FIFO emptied, so m_req=0 until a new request arrives.
  - i/d_addr_ok and i/d_data_ok read 0.
- Grant selection (sel: 0=inst, 1=data):
  - If lock_valid, sel=lock_sel.
  - Otherwise data wins when d_req=1; else inst.
- m_req = (sel ? d_req : i_req) & ~fifo_full. m_wr, m_size, m_wstrb, m_addr and m_wdata are muxed from sel. Zero latency, combinational.
- Lock (2-state FSM, FREE/HELD):
  - FREE->HELD when m_req & ~m_addr_ok; lock_sel is recorded.
  - HELD->FREE on m_req & m_addr_ok.
  - Guarantees request fields stay stable until accepted. A data request arriving while inst is HELD waits.
- Accept: addr_ok is forwarded only to the selected requester: x_addr_ok = m_addr_ok & m_req & (sel==x). The other requester sees 0.
- Owner FIFO, OUTSTANDING entries x 1 bit:
  - Push sel on m_req & m_addr_ok.
  - Pop on m_data_ok & ~fifo_empty.
  - Count width $clog2(OUTSTANDING+1).
  - Push and pop in the same cycle: count unchanged, pointers both advance and wrap modulo OUTSTANDING.
- Full: m_req is forced 0 while count==OUTSTANDING, even if m_data_ok=1 in that cycle (no bypass). The request is issued next cycle.
- Response routing:
  - x_data_ok = m_data_ok & ~fifo_empty & (head==x).
  - i_rdata = d_rdata = m_rdata; no mux is needed because only one data_ok fires.
- m_data_ok while fifo empty is a protocol violation: dropped, nothing forwarded.
- Responses are strictly in order. Downstream must return data_ok in acceptance order.

Optional Feature:
- ARB_RR_EN defined: when FREE and both requests are present, grant alternates. A 1-bit last_grant register is updated on every accept; the requester not granted last wins. Reset value of last_grant = 1, so inst wins first.
- ARB_RR_EN undefined: fixed data-over-inst priority as above; no last_grant register.

Decomposition:
- Shared package/header: OUTSTANDING default, SEL_INST=0/SEL_DATA=1 constants, lock-state encodings.
- One sub-module: arb_owner_fifo, a parameterised 1-bit-wide sync FIFO with async reset and full/empty/count outputs.
- Grant, lock and muxing stay in the top.

Test Plan:
- Inst-only read, addr 0x1C000000, m_addr_ok same cycle, m_data_ok 2 cycles later with rdata 0x02800C0C -> i_addr_ok=1 in cycle 0; i_data_ok=1 with i_rdata=0x02800C0C; d_* outputs stay 0.
- i_req and d_req both asserted, m_addr_ok=1 -> data granted first (m_addr=d_addr). Inst is granted the next cycle. Responses return d then i in order.
- Inst req stalled with m_addr_ok=0 for 3 cycles, d_req rises in cycle 1 -> m_addr stays i_addr until accepted; data is granted afterwards.
- Issue 4 accepted requests with no data_ok (OUTSTANDING=4) -> m_req=0 in the 5th cycle, even if m_data_ok=1 that cycle. m_req=1 next cycle. Ownership bits pop in order.
- Reset asserted with 2 transactions outstanding, then a stray m_data_ok after release -> fifo empty, no i/d_data_ok pulse.
- ARB_RR_EN defined, both requesting continuously, m_addr_ok=1 -> grants alternate i,d,i,d; fixed build gives d,d,d,d.
